// File: rtl/fifo_ctrl_arb.sv
// fifo_ctrl_arb: front-end controller for a flagless FIFO datapath.
// It arbitrates two producers onto the write port in round-robin order,
// gates consumer pops, tracks occupancy for full/empty, and runs a flush
// sequence that drains the FIFO.
module fifo_ctrl_arb #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    input  logic              rd_req,
    output logic              rd_valid,
    input  logic              flush,
    output logic              flush_done,
    output logic [DATA_W-1:0] fifo_data_in,
    output logic              fifo_en_write,
    output logic              fifo_en_read,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               rr_last_reg, rr_last_next;
    logic               rd_valid_reg, rd_valid_next;
    logic               flush_done_reg, flush_done_next;
    logic               in_run;
    logic               wr_ok;

    assign in_run = (state_reg == RUN);
    assign full   = (count_reg == CNT_W'(DEPTH));
    assign empty  = (count_reg == '0);
    assign count  = count_reg;

    // Writes are refused whenever full, even if a pop lands on the same edge,
    // so correctness never depends on the FIFO's same-edge read/write behaviour.
    assign wr_ok = in_run && !full;

    // On a tie the producer that was not granted last wins.
    assign gnt0 = wr_ok && req0 && (!req1 || rr_last_reg);
    assign gnt1 = wr_ok && req1 && (!req0 || !rr_last_reg);
    assign fifo_en_write = gnt0 || gnt1;

    // During a flush every non-empty cycle pops, regardless of rd_req.
    assign fifo_en_read = in_run ? (rd_req && !empty) : !empty;

    // Per-bit write-data mux; producer 0 data is the idle default.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_data_mux
            assign fifo_data_in[gi] = gnt1 ? data1[gi] : data0[gi];
        end
    endgenerate

    assign rd_valid   = rd_valid_reg;
    assign flush_done = flush_done_reg;

    // Next-state logic: enter FLUSH on request, return to RUN once drained.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (flush) state_next = FLUSH;
            FLUSH:   if (empty) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Occupancy, arbitration history and registered status pulses.
    always_comb begin
        count_next      = count_reg;
        rr_last_next    = rr_last_reg;
        rd_valid_next   = in_run && fifo_en_read;
        flush_done_next = (state_reg == FLUSH) && empty;
        if (fifo_en_write && !fifo_en_read) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!fifo_en_write && fifo_en_read) begin
            count_next = count_reg - CNT_W'(1);
        end
        if (gnt1) begin
            rr_last_next = 1'b1;
        end else if (gnt0) begin
            rr_last_next = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers; rr_last resets to 1 so producer 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg      <= '0;
            rr_last_reg    <= 1'b1;
            rd_valid_reg   <= 1'b0;
            flush_done_reg <= 1'b0;
        end else begin
            count_reg      <= count_next;
            rr_last_reg    <= rr_last_next;
            rd_valid_reg   <= rd_valid_next;
            flush_done_reg <= flush_done_next;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_arb.sv
// Scoreboard bench for fifo_ctrl_arb: the stimulus process queues the
// hand-computed expected outputs of each cycle; the monitor pops and compares.
module tb_fifo_ctrl_arb;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, rd_req = 1'b0, flush = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       gnt0, gnt1, rd_valid, flush_done;
    logic       fifo_en_write, fifo_en_read, full, empty;
    logic [7:0] fifo_data_in;
    logic [4:0] count;

    fifo_ctrl_arb #(.DATA_W(8), .DEPTH(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .gnt1(gnt1),
        .rd_req(rd_req), .rd_valid(rd_valid),
        .flush(flush), .flush_done(flush_done),
        .fifo_data_in(fifo_data_in), .fifo_en_write(fifo_en_write),
        .fifo_en_read(fifo_en_read), .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       g0, g1, ew, er, rv, fd, fu, em;
        logic [4:0] cnt;
        logic [7:0] din;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_push = 0;

    // Drive one cycle of inputs and queue what the outputs must show in it.
    task automatic cyc(input logic rst, input logic r0, input logic [7:0] d0,
                       input logic r1, input logic [7:0] d1,
                       input logic rd, input logic fl,
                       input logic eg0, input logic eg1, input logic erd,
                       input logic [4:0] ecnt, input logic erv, input logic efd);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; req0 = r0; data0 = d0; req1 = r1; data1 = d1;
        rd_req = rd; flush = fl;
        e.id  = n_push;
        e.g0  = eg0;
        e.g1  = eg1;
        e.ew  = eg0 | eg1;
        e.er  = erd;
        e.rv  = erv;
        e.fd  = efd;
        e.cnt = ecnt;
        e.fu  = (ecnt == 5'd16);
        e.em  = (ecnt == 5'd0);
        e.din = eg1 ? d1 : d0;
        n_push++;
        exp_q.push_back(e);
    endtask

    function automatic bit chk(input int id, input string nm,
                               input logic [7:0] got, input logic [7:0] want);
        if (got !== want) begin
            $display("FAIL v%0d %s: got %0h expected %0h", id, nm, got, want);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Monitor: compare the oldest queued expectation mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   bad;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            bad = 1'b0;
            n_vec++;
            bad |= chk(e.id, "gnt0",          8'(gnt0),          8'(e.g0));
            bad |= chk(e.id, "gnt1",          8'(gnt1),          8'(e.g1));
            bad |= chk(e.id, "fifo_en_write", 8'(fifo_en_write), 8'(e.ew));
            bad |= chk(e.id, "fifo_en_read",  8'(fifo_en_read),  8'(e.er));
            bad |= chk(e.id, "rd_valid",      8'(rd_valid),      8'(e.rv));
            bad |= chk(e.id, "flush_done",    8'(flush_done),    8'(e.fd));
            bad |= chk(e.id, "full",          8'(full),          8'(e.fu));
            bad |= chk(e.id, "empty",         8'(empty),         8'(e.em));
            bad |= chk(e.id, "count",         8'(count),         8'(e.cnt));
            bad |= chk(e.id, "fifo_data_in",  fifo_data_in,      e.din);
            if (bad) n_miss++;
            $display("vec %0d: cnt=%0d g0=%b g1=%b rd=%b rv=%b fd=%b %s",
                     e.id, count, gnt0, gnt1, fifo_en_read, rd_valid, flush_done,
                     bad ? "bad" : "ok");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);

        // Reset state, then producer 0 alone fills the FIFO; 17th request refused.
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 5'd0, 0, 0);
        for (int i = 0; i < 16; i++)
            cyc(0, 1, 8'(8'h10 + i), 0, 8'h00, 0, 0,  1, 0, 0, 5'(i), 0, 0);
        cyc(0, 1, 8'h20, 0, 8'h00, 0, 0,  0, 0, 0, 5'd16, 0, 0);
        cyc(1, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 5'd16, 0, 0);

        // Both producers requesting: grants alternate starting with producer 0.
        for (int i = 0; i < 6; i++)
            cyc(0, 1, 8'(8'hA0 + i), 1, 8'(8'hB0 + i), 0, 0,
                (i % 2 == 0), (i % 2 == 1), 0, 5'(i), 0, 0);
        cyc(1, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 5'd6, 0, 0);

        // Producer 1 fills, then the consumer drains all 16; 17th pop blocked.
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 8'h00, 1, 8'(8'h30 + i), 0, 0,  0, 1, 0, 5'(i), 0, 0);
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 1, 5'(16 - i), (i > 0), 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 5'd0, 1, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 5'd0, 0, 0);

        // Count 5 with simultaneous write+read holds steady; read+write at empty.
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 8'(8'h40 + i), 0, 8'h00, 0, 0,  1, 0, 0, 5'(i), 0, 0);
        for (int j = 0; j < 4; j++)
            cyc(0, 1, 8'(8'h50 + j), 0, 8'h00, 1, 0,  1, 0, 1, 5'd5, (j > 0), 0);
        for (int k = 0; k < 5; k++)
            cyc(0, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 1, 5'(5 - k), 1, 0);
        cyc(0, 1, 8'h60, 0, 8'h00, 1, 0,  1, 0, 0, 5'd0, 1, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 5'd1, 0, 0);

        // Flush at count 3 with req0/rd_req held: three silent pops, no grants.
        cyc(0, 1, 8'h70, 0, 8'h00, 0, 0,  1, 0, 0, 5'd1, 0, 0);
        cyc(0, 1, 8'h71, 0, 8'h00, 0, 0,  1, 0, 0, 5'd2, 0, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 5'd3, 0, 0);
        cyc(0, 1, 8'h72, 0, 8'h00, 1, 0,  0, 0, 1, 5'd3, 0, 0);
        cyc(0, 1, 8'h73, 0, 8'h00, 1, 1,  0, 0, 1, 5'd2, 0, 0);
        cyc(0, 1, 8'h74, 0, 8'h00, 1, 0,  0, 0, 1, 5'd1, 0, 0);
        cyc(0, 1, 8'h75, 0, 8'h00, 1, 0,  0, 0, 0, 5'd0, 0, 0);
        cyc(0, 1, 8'h76, 0, 8'h00, 1, 0,  1, 0, 0, 5'd0, 0, 1);
        cyc(0, 1, 8'h77, 0, 8'h00, 1, 0,  1, 0, 1, 5'd1, 0, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 5'd1, 1, 0);

        // Flush when already empty: one FLUSH cycle, then flush_done.
        cyc(0, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 1, 5'd1, 0, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 5'd0, 1, 0);
        cyc(0, 1, 8'h78, 0, 8'h00, 0, 0,  0, 0, 0, 5'd0, 0, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 5'd0, 0, 1);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 5'd0, 0, 0);

        // Reset during FLUSH at count 2; afterwards RUN with rr_last back at 1.
        cyc(0, 1, 8'h80, 0, 8'h00, 0, 0,  1, 0, 0, 5'd0, 0, 0);
        cyc(0, 1, 8'h81, 0, 8'h00, 0, 0,  1, 0, 0, 5'd1, 0, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 5'd2, 0, 0);
        cyc(1, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 1, 5'd2, 0, 0);
        cyc(0, 1, 8'h90, 1, 8'h91, 0, 0,  1, 0, 0, 5'd0, 0, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 5'd1, 0, 0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
